// File: rtl/tdc_pkg.sv
// Shared types and helpers for the TDC measurement sequencer.
package tdc_pkg;

   // Sequencer states
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LAUNCH  = 3'd1,
      ST_SETTLE  = 3'd2,
      ST_CAPTURE = 3'd3,
      ST_DONE    = 3'd4
   } state_e;

   // Width of a hamming-weight word for an n-stage delay line
   function automatic int unsigned hw_width(input int unsigned n);
      return int'($clog2(n)) + 1;
   endfunction

endpackage : tdc_pkg

// File: rtl/tdc_stat_accum.sv
// Sample statistics: running sum, min, max and sticky out-of-range flag.
module tdc_stat_accum #(
   parameter int unsigned N     = 64,
   parameter int unsigned HW_W  = 7,
   parameter int unsigned SUM_W = 11
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             upd,
   input  logic [HW_W-1:0]  hw,
   output logic [SUM_W-1:0] hw_sum,
   output logic [HW_W-1:0]  hw_min,
   output logic [HW_W-1:0]  hw_max,
   output logic             range_err
);

   // Clear on a new measurement, fold in one sample per update
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         hw_sum    <= '0;
         hw_min    <= '1;
         hw_max    <= '0;
         range_err <= 1'b0;
      end else if (upd) begin
         hw_sum <= hw_sum + SUM_W'(hw);
         if (hw < hw_min) hw_min <= hw;
         if (hw > hw_max) hw_max <= hw;
         // out-of-range samples are still accumulated above
         if (hw > HW_W'(N)) range_err <= 1'b1;
      end
   end

endmodule : tdc_stat_accum

// File: rtl/tdc_meas_ctrl.sv
// Measurement sequencer: launch, settle, capture hw, repeat 2^LOG2_SAMPLES times.
module tdc_meas_ctrl
   import tdc_pkg::*;
#(
   parameter int unsigned N             = 64,
   parameter int unsigned LOG2_SAMPLES  = 4,
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   start,
   input  logic [hw_width(N)-1:0]                 hw,
   output logic                                   pg_tog,
   output logic                                   cap_strobe,
   output logic                                   busy,
   output logic                                   done,
   output logic [hw_width(N)+LOG2_SAMPLES-1:0]    hw_sum,
   output logic [hw_width(N)-1:0]                 hw_min,
   output logic [hw_width(N)-1:0]                 hw_max,
   output logic                                   range_err
);

   localparam int unsigned HW_W   = hw_width(N);
   localparam int unsigned SUM_W  = HW_W + LOG2_SAMPLES;
   localparam int unsigned NSAMP  = 1 << LOG2_SAMPLES;
   localparam int unsigned SCNT_W = (LOG2_SAMPLES == 0) ? 1 : LOG2_SAMPLES;
   localparam int unsigned STL_W  = 8;

   state_e              state_q;
   state_e              state_d;
   logic [SCNT_W-1:0]   smp_cnt;
   logic [STL_W-1:0]    settle_cnt;
   logic                smp_last;
   logic                stat_clr;
   logic                stat_upd;

   assign smp_last = (smp_cnt == SCNT_W'(NSAMP - 1));

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (start) state_d = ST_LAUNCH;
         ST_LAUNCH:  state_d = ST_SETTLE;
         ST_SETTLE:  if (settle_cnt == '0) state_d = ST_CAPTURE;
         ST_CAPTURE: state_d = smp_last ? ST_DONE : ST_LAUNCH;
         ST_DONE:    state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // State-decoded strobes and accumulator controls
   always_comb begin
      cap_strobe = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      stat_clr   = 1'b0;
      stat_upd   = 1'b0;
      case (state_q)
         ST_IDLE:    stat_clr = start;
         ST_LAUNCH:  busy = 1'b1;
         ST_SETTLE:  busy = 1'b1;
         ST_CAPTURE: begin
            busy       = 1'b1;
            cap_strobe = 1'b1;
            stat_upd   = 1'b1;
         end
         ST_DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: ;
      endcase
   end

   // Launch toggle, settle timer and sample counter
   always_ff @(posedge clk) begin
      if (rst) begin
         pg_tog     <= 1'b0;
         settle_cnt <= '0;
         smp_cnt    <= '0;
      end else begin
         case (state_q)
            ST_IDLE: if (start) smp_cnt <= '0;
            ST_LAUNCH: begin
               pg_tog     <= ~pg_tog;
               settle_cnt <= STL_W'(SETTLE_CYCLES - 1);
            end
            ST_SETTLE: if (settle_cnt != '0) settle_cnt <= settle_cnt - STL_W'(1);
            ST_CAPTURE: if (!smp_last) smp_cnt <= smp_cnt + SCNT_W'(1);
            default: ;
         endcase
      end
   end

   tdc_stat_accum #(
      .N     (N),
      .HW_W  (HW_W),
      .SUM_W (SUM_W)
   ) u_stat (
      .clk       (clk),
      .rst       (rst),
      .clr       (stat_clr),
      .upd       (stat_upd),
      .hw        (hw),
      .hw_sum    (hw_sum),
      .hw_min    (hw_min),
      .hw_max    (hw_max),
      .range_err (range_err)
   );

endmodule : tdc_meas_ctrl

// File: doc/tdc_meas_ctrl.md
Name: tdc_meas_ctrl

Overview:
On-chip measurement sequencer that drives the launch side of tdc_top and consumes its hamming-weight result.
- Per sample: issues one launch toggle, waits a programmable settle time covering delay-line propagation and tdc_top's n_sync synchronizer, then samples hw.
- Accumulates over 2^LOG2_SAMPLES samples and reports sum, min, max and a range error.
- Replaces manual pin toggling of pg_tog/pg_in from the test harness.

Parameters:
N, 64, delay-line length; hw is $clog2(N)+1 bits wide.
LOG2_SAMPLES, 4, log2 of samples per measurement (16 by default); legal range 0..8.
SETTLE_CYCLES, 4, clk cycles between launch and capture; must be >= n_sync+1 of tdc_top; legal range 1..255.

Ports:
clk  input  1  single system clock.
rst  input  1  synchronous, active-high reset.
start  input  1  level-sampled request; acted on only in IDLE.
hw  input  $clog2(N)+1  hamming weight from tdc_top, already synchronized to clk.
pg_tog  output  1  launch toggle to tdc_top; inverts once per sample.
cap_strobe  output  1  one-cycle pulse marking the cycle hw is sampled (debug/scope).
busy  output  1  high from the cycle after start is accepted until DONE exits.
done  output  1  one-cycle pulse; results valid from this cycle.
hw_sum  output  $clog2(N)+1+LOG2_SAMPLES  sum of all samples; cannot overflow by width.
hw_min  output  $clog2(N)+1  minimum sample.
hw_max  output  $clog2(N)+1  maximum sample.
range_err  output  1  set if any sample had hw > N.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE.
  - pg_tog, cap_strobe, busy, done, range_err = 0.
  - hw_sum=0, hw_min=all-ones, hw_max=0.
  - Reset mid-measurement aborts immediately; no done pulse is generated.
- FSM states: IDLE, LAUNCH, SETTLE, CAPTURE, DONE.
- IDLE:
  - If start=1: clear sum to 0, min to all-ones, max to 0, range_err to 0, and sample counter to 0; go to LAUNCH.
  - Previous results hold until this clear.
- LAUNCH (1 cycle): pg_tog <= ~pg_tog; load settle counter with SETTLE_CYCLES-1; go to SETTLE.
- SETTLE: decrement counter each cycle; at 0 go to CAPTURE. Launch-to-capture latency is exactly SETTLE_CYCLES+1 clk edges.
- CAPTURE (1 cycle):
  - cap_strobe=1 (combinational from state).
  - sum += hw.
  - min = (hw < min) ? hw : min; max = (hw > max) ? hw : max.
  - If hw > N, set range_err (sticky). The sample is still accumulated.
  - If counter == 2^LOG2_SAMPLES-1, go to DONE; otherwise increment counter and go to LAUNCH.
- DONE (1 cycle): done=1; go to IDLE.
- busy=1 in LAUNCH, SETTLE, CAPTURE and DONE.
- start is ignored in all non-IDLE states. start held high continuously produces back-to-back measurements separated by one IDLE cycle.
- pg_tog is not reset by completion. Its parity after a measurement equals its parity before XOR (2^LOG2_SAMPLES odd?), i.e. unchanged when LOG2_SAMPLES >= 1.
- Measurement length is 2^LOG2_SAMPLES * (SETTLE_CYCLES+2) cycles from LAUNCH entry to DONE, plus 1 cycle for DONE.
- All outputs are registered except cap_strobe, busy and done, which are decoded from the state register.

Decomposition:
- tdc_pkg (shared): state enum typedef; function hw_width(N) = $clog2(N)+1.
- Sub-module tdc_stat_accum: sum/min/max/range_err registers with clear and update inputs.
- The FSM and counters stay in tdc_meas_ctrl.

Test Plan:
- Reset, then start=1 for 1 cycle with hw held at 32 (defaults) -> done after 16*6+1 cycles; hw_sum=512, hw_min=32, hw_max=32, range_err=0; pg_tog toggled 16 times, ending at 0.
- hw ramps 10,11,...,25 across the 16 CAPTURE cycles -> hw_sum=280, hw_min=10, hw_max=25; cap_strobe pulses exactly 16 times, each SETTLE_CYCLES+1=5 cycles after its pg_tog edge.
- One sample hw=70 (>64), others 0 -> range_err=1, hw_sum=70, hw_max=70, hw_min=0.
- Assert rst during the 5th SETTLE -> next cycle busy=0, hw_sum=0, pg_tog=0; no done pulse. A fresh start then completes normally.
- Pulse start again while busy mid-measurement -> no restart; exactly one done pulse, at the original expected cycle.
- LOG2_SAMPLES=0, SETTLE_CYCLES=1, hw=64 -> done 4 cycles after start is accepted; hw_sum=64=min=max; pg_tog=1.
